// File: rtl/input_dir_ctrl_if.sv
// input_dir_ctrl_if: raw push-buttons in, debounced levels and direction/heading out
interface input_dir_ctrl_if;
  logic ubtn, dbtn, rbtn, lbtn;
  logic [3:0] btn_state, move_dir, cur_dir;
  logic dir_valid;
  modport master (output ubtn, dbtn, rbtn, lbtn, input btn_state, move_dir, cur_dir, dir_valid);
  modport slave (input ubtn, dbtn, rbtn, lbtn, output btn_state, move_dir, cur_dir, dir_valid);
endinterface

// File: rtl/input_dir_ctrl.sv
// input_dir_ctrl: synchronise, debounce and priority-encode buttons into a heading with move strobes
module input_dir_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_CYCLES = 24'd0,
  parameter logic ALLOW_REVERSE = 1'b0,
  parameter logic [3:0] INIT_DIR = 4'b0001
) (
  input logic clk,
  input logic rst_n,
  input_dir_ctrl_if.slave bus
);
  localparam int CW = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
  typedef enum logic {IDLE, HOLD} state_t;
  logic [1:0] rst_q;
  logic rst_i_n;
  logic [3:0] raw, s1, s2, btn_q, move_dir, enc_q, cur_q, cur_n, opp;
  logic [23:0] rcnt, rcnt_n;
  logic issue, dv_q, dv_n;
  state_t state, state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_i_n = rst_q[1];
  assign raw = {bus.lbtn, bus.dbtn, bus.ubtn, bus.rbtn};
  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) {s2, s1} <= '0;
    else {s2, s1} <= {s1, raw};
  // a level is accepted only after it has disagreed with btn_state for DEBOUNCE_CYCLES+1 edges
  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic st;
    always_ff @(posedge clk or negedge rst_i_n)
      if (!rst_i_n) begin
        cnt <= '0;
        st <= 1'b0;
      end else if (s2[i] == st) cnt <= '0;
      else if (cnt == DB_MAX) begin
        cnt <= '0;
        st <= s2[i];
      end else cnt <= cnt + CW'(1);
    assign btn_q[i] = st;
  end
  assign move_dir = btn_q[1] ? 4'b0010 : btn_q[2] ? 4'b0100 : btn_q[0] ? 4'b0001 : btn_q[3] ? 4'b1000 : 4'b0000;
  assign opp = {cur_q[0], cur_q[1], cur_q[2], cur_q[3]};
  always_comb begin
    state_n = state;
    rcnt_n = rcnt;
    issue = 1'b0;
    if (state == IDLE) begin
      if (move_dir != 4'b0) begin
        state_n = HOLD;
        rcnt_n = '0;
        issue = 1'b1;
      end
    end else if (move_dir == 4'b0) state_n = IDLE;
    else if (move_dir != enc_q) begin
      rcnt_n = '0;
      issue = 1'b1;
    end else if (REPEAT_CYCLES != 24'd0) begin
      issue = rcnt == REPEAT_CYCLES - 24'd1;
      rcnt_n = issue ? '0 : rcnt + 24'd1;
    end
    dv_n = issue && (ALLOW_REVERSE || move_dir != opp);
    cur_n = dv_n ? move_dir : cur_q;
  end
  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) begin
      state <= IDLE;
      rcnt <= '0;
      enc_q <= '0;
      cur_q <= INIT_DIR;
      dv_q <= 1'b0;
    end else begin
      state <= state_n;
      rcnt <= rcnt_n;
      enc_q <= move_dir;
      cur_q <= cur_n;
      dv_q <= dv_n;
    end
  assign bus.btn_state = btn_q;
  assign bus.move_dir = move_dir;
  assign bus.cur_dir = cur_q;
  assign bus.dir_valid = dv_q;
endmodule
